// File: rtl/ascan_trigger_sequencer.sv
// ---------------------------------------------------------------------------
// ascan_trigger_sequencer
//
// Converts single-cycle timeout ticks from the interval timer into A-line
// trigger pulses of programmable width, groups those lines into B-scan frames
// and raises an end-of-frame interrupt. Software controls the block through a
// 16-bit Avalon-MM slave laid out like the interval timer's register file.
//
// Register map (word addresses):
//   0 STATUS   rd {overrun, frame_done, running}; any write clears the sticky bits
//   1 CONTROL  rd/wr {stop, start, continuous, irq_en}; start/stop are strobes
//   2 PW       rd/wr trigger pulse width in clk cycles (0 behaves as 1)
//   3 LINES    rd/wr lines per frame (0 behaves as 1)
//   4 LINECNT  rd current line index within the frame
//   5 FRAMECNT rd completed frames (wraps); writable so it can be preset
//   6,7        reserved, read 0
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   tick       single-cycle timeout pulse from the interval timer
//   address    Avalon word address
//   chipselect Avalon chip select
//   write_n    Avalon write strobe, active-low
//   writedata  Avalon write data
//   readdata   Avalon read data, registered (one cycle latency)
//   irq        frame_done && irq_en
//   trig_out   A-line trigger to the digitizer/laser
//   frame_sync trig_out qualified with line 0 of the frame
// ---------------------------------------------------------------------------
module ascan_trigger_sequencer #(
    parameter logic [15:0] PW_RESET    = 16'd10,
    parameter logic [15:0] LINES_RESET = 16'd512
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq,
    output logic        trig_out,
    output logic        frame_sync
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam logic [2:0] A_STATUS   = 3'd0;
    localparam logic [2:0] A_CONTROL  = 3'd1;
    localparam logic [2:0] A_PW       = 3'd2;
    localparam logic [2:0] A_LINES    = 3'd3;
    localparam logic [2:0] A_LINECNT  = 3'd4;
    localparam logic [2:0] A_FRAMECNT = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  state_reg,      state_next;
    logic        trig_reg,       trig_next;
    logic [15:0] pw_cnt_reg,     pw_cnt_next;
    logic [15:0] line_cnt_reg,   line_cnt_next;
    logic [15:0] pw_work_reg;
    logic [15:0] lines_work_reg;
    logic [15:0] pw_reg;
    logic [15:0] lines_reg;
    logic [1:0]  ctrl_reg;          // {continuous, irq_en}
    logic        overrun_reg;
    logic        frame_done_reg;
    logic [15:0] frame_cnt_reg;
    logic [15:0] readdata_reg;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic wr;
    logic wr_status, wr_ctrl, wr_pw, wr_lines, wr_framecnt;
    logic start_req, stop_req, ctrl_cmd;

    assign wr          = chipselect && !write_n;
    assign wr_status   = wr && (address == A_STATUS);
    assign wr_ctrl     = wr && (address == A_CONTROL);
    assign wr_pw       = wr && (address == A_PW);
    assign wr_lines    = wr && (address == A_LINES);
    assign wr_framecnt = wr && (address == A_FRAMECNT);

    // Stop dominates a simultaneous start.
    assign stop_req  = wr_ctrl && writedata[3];
    assign start_req = wr_ctrl && writedata[2] && !writedata[3];
    // Either command truncates a pulse in flight during the write cycle itself.
    assign ctrl_cmd  = stop_req || start_req;

    // Zero-valued width/length registers behave as 1.
    logic [15:0] pw_eff, lines_eff;
    assign pw_eff    = (pw_reg    == 16'd0) ? 16'd1 : pw_reg;
    assign lines_eff = (lines_reg == 16'd0) ? 16'd1 : lines_reg;

    logic last_line;
    assign last_line = (line_cnt_reg == (lines_work_reg - 16'd1));

    // ------------------------------------------------------------------
    // Sequencer next-state logic
    // ------------------------------------------------------------------
    logic relatch;      // copy PW/LINES into the working registers
    logic frame_tick;   // a frame completed on this edge
    logic overrun_set;

    always_comb begin
        state_next    = state_reg;
        trig_next     = trig_reg;
        pw_cnt_next   = pw_cnt_reg;
        line_cnt_next = line_cnt_reg;
        relatch       = 1'b0;
        frame_tick    = 1'b0;
        overrun_set   = tick && (state_reg == ST_PULSE);

        if (stop_req) begin
            state_next = ST_IDLE;
            trig_next  = 1'b0;
        end else if (start_req) begin
            state_next    = ST_ARMED;
            trig_next     = 1'b0;
            line_cnt_next = 16'd0;
            relatch       = 1'b1;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (tick) begin
                        state_next  = ST_PULSE;
                        trig_next   = 1'b1;
                        pw_cnt_next = 16'd1;
                    end
                end
                ST_PULSE: begin
                    if (pw_cnt_reg >= pw_work_reg) begin
                        // Falling edge of the trigger: the line is complete.
                        trig_next = 1'b0;
                        if (last_line) begin
                            frame_tick    = 1'b1;
                            line_cnt_next = 16'd0;
                            if (ctrl_reg[1]) begin
                                relatch    = 1'b1;
                                state_next = ST_ARMED;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end else begin
                            line_cnt_next = line_cnt_reg + 16'd1;
                            state_next    = ST_ARMED;
                        end
                    end else begin
                        pw_cnt_next = pw_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    // IDLE ignores ticks.
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            trig_reg       <= 1'b0;
            pw_cnt_reg     <= 16'd0;
            line_cnt_reg   <= 16'd0;
            pw_work_reg    <= PW_RESET;
            lines_work_reg <= LINES_RESET;
        end else begin
            state_reg    <= state_next;
            trig_reg     <= trig_next;
            pw_cnt_reg   <= pw_cnt_next;
            line_cnt_reg <= line_cnt_next;
            if (relatch) begin
                pw_work_reg    <= pw_eff;
                lines_work_reg <= lines_eff;
            end
        end
    end

    // ------------------------------------------------------------------
    // Software-visible registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pw_reg         <= PW_RESET;
            lines_reg      <= LINES_RESET;
            ctrl_reg       <= 2'b00;
            overrun_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= 16'd0;
        end else begin
            if (wr_pw)    pw_reg    <= writedata;
            if (wr_lines) lines_reg <= writedata;
            if (wr_ctrl)  ctrl_reg  <= writedata[1:0];

            // Hardware set beats a software clear in the same cycle.
            if (overrun_set)    overrun_reg <= 1'b1;
            else if (wr_status) overrun_reg <= 1'b0;

            if (frame_tick)     frame_done_reg <= 1'b1;
            else if (wr_status) frame_done_reg <= 1'b0;

            if (frame_tick)       frame_cnt_reg <= frame_cnt_reg + 16'd1;
            else if (wr_framecnt) frame_cnt_reg <= writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic        running;
    logic [15:0] rd_mux;

    assign running = (state_reg != ST_IDLE);

    always_comb begin
        rd_mux = 16'd0;
        case (address)
            A_STATUS:   rd_mux = {13'd0, overrun_reg, frame_done_reg, running};
            A_CONTROL:  rd_mux = {14'd0, ctrl_reg};
            A_PW:       rd_mux = pw_reg;
            A_LINES:    rd_mux = lines_reg;
            A_LINECNT:  rd_mux = line_cnt_reg;
            A_FRAMECNT: rd_mux = frame_cnt_reg;
            default:    rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg <= 16'd0;
        end else begin
            readdata_reg <= chipselect ? rd_mux : 16'd0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign readdata   = readdata_reg;
    assign irq        = frame_done_reg && ctrl_reg[0];
    // A stop/start write pulls the trigger low in the same cycle.
    assign trig_out   = trig_reg && !ctrl_cmd;
    assign frame_sync = trig_out && (line_cnt_reg == 16'd0);

endmodule
